pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard sources, in priority order:
- multi-cycle data-memory wait;
- taken branch resolved in EX;
- load-use dependency between ID and EX.

It also runs a memory-wait watchdog that halts the pipeline on a timeout.

---
 rtl/pipeline_hazard_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait, taken branch and load-use resolution plus a memory-wait watchdog.
// Optional performance counters are enabled with `define HAZARD_PERF_COUNTERS_EN.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 3,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  if_id_flush,
    output logic                  id_ex_write_en,
    output logic                  id_ex_flush,
    output logic                  ex_mem_write_en,
    output logic                  mem_wb_write_en,
    output logic                  halted
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
`endif
);

    // Counter is wide enough to hold MEM_TIMEOUT and still saturate above it.
    localparam int                WCNT_W    = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WCNT_W-1:0] TIMEOUT_C = WCNT_W'(MEM_TIMEOUT);
    localparam bit                WD_EN     = (MEM_TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic rs1_hit_s, rs2_hit_s, load_use_s, mem_stall_s;
    logic nrm_pc_we_s, nrm_ifid_we_s, nrm_ifid_fl_s, nrm_idex_fl_s;

    // Hazard detection terms; register 0 never creates a dependency.
    always_comb begin
        rs1_hit_s   = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit_s   = id_uses_rs2 && (id_rs2 == ex_rd);
        load_use_s  = ex_mem_read && (ex_rd != {REG_ADDR_W{1'b0}}) && (rs1_hit_s || rs2_hit_s);
        mem_stall_s = mem_req && !mem_ready;
    end

    // Normal evaluation without the memory-stall term: branch squashes ID, so it outranks load-use.
    always_comb begin
        nrm_pc_we_s   = 1'b1;
        nrm_ifid_we_s = 1'b1;
        nrm_ifid_fl_s = 1'b0;
        nrm_idex_fl_s = 1'b0;
        if (ex_branch_taken) begin
            nrm_ifid_fl_s = 1'b1;
            nrm_idex_fl_s = 1'b1;
        end else if (load_use_s) begin
            nrm_pc_we_s   = 1'b0;
            nrm_ifid_we_s = 1'b0;
            nrm_idex_fl_s = 1'b1;
        end else begin
            nrm_pc_we_s   = 1'b1;
            nrm_ifid_we_s = 1'b1;
        end
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_INIT;
            wait_cnt_q <= {WCNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic and Mealy control outputs.
    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        pc_write_en     = 1'b0;
        if_id_write_en  = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_write_en  = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_write_en = 1'b0;
        mem_wb_write_en = 1'b0;
        halted          = 1'b0;
        case (state_q)
            S_INIT: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                wait_cnt_d  = {WCNT_W{1'b0}};
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (mem_stall_s) begin
                    wait_cnt_d = {{(WCNT_W-1){1'b0}}, 1'b1};
                    state_d    = S_MEM_WAIT;
                end else begin
                    pc_write_en     = nrm_pc_we_s;
                    if_id_write_en  = nrm_ifid_we_s;
                    if_id_flush     = nrm_ifid_fl_s;
                    id_ex_write_en  = 1'b1;
                    id_ex_flush     = nrm_idex_fl_s;
                    ex_mem_write_en = 1'b1;
                    mem_wb_write_en = 1'b1;
                    state_d         = S_RUN;
                end
            end
            S_MEM_WAIT: begin
                if (mem_ready) begin
                    pc_write_en     = nrm_pc_we_s;
                    if_id_write_en  = nrm_ifid_we_s;
                    if_id_flush     = nrm_ifid_fl_s;
                    id_ex_write_en  = 1'b1;
                    id_ex_flush     = nrm_idex_fl_s;
                    ex_mem_write_en = 1'b1;
                    mem_wb_write_en = 1'b1;
                    wait_cnt_d      = {WCNT_W{1'b0}};
                    state_d         = S_RUN;
                end else begin
                    if (wait_cnt_q != {WCNT_W{1'b1}}) begin
                        wait_cnt_d = wait_cnt_q + {{(WCNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                    if (WD_EN && (wait_cnt_q == TIMEOUT_C)) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_MEM_WAIT;
                    end
                end
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: begin
                state_d    = S_INIT;
                wait_cnt_d = {WCNT_W{1'b0}};
            end
        endcase
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_W-1:0] stall_cycles_q, flush_events_q;
    logic             stall_inc_s, flush_inc_s;

    // Increment qualifiers: stalls count only in active states, flushes outside the post-reset flush.
    always_comb begin
        stall_inc_s = !pc_write_en && ((state_q == S_RUN) || (state_q == S_MEM_WAIT));
        flush_inc_s = if_id_flush && (state_q != S_INIT);
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= {CNT_W{1'b0}};
            flush_events_q <= {CNT_W{1'b0}};
        end else begin
            if (stall_inc_s && (stall_cycles_q != {CNT_W{1'b1}})) begin
                stall_cycles_q <= stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cycles_q <= stall_cycles_q;
            end
            if (flush_inc_s && (flush_events_q != {CNT_W{1'b1}})) begin
                flush_events_q <= flush_events_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_events_q <= flush_events_q;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed table-driven bench for pipeline_hazard_ctrl; a second instance with MEM_TIMEOUT=4 exercises the watchdog.
module tb_pipeline_hazard_ctrl;

    localparam int AW = 3;

    // Observation order: {pc, if_id_we, if_id_fl, id_ex_we, id_ex_fl, ex_mem_we, mem_wb_we, halted}
    localparam logic [7:0] E_RUN   = 8'b1101_0110;
    localparam logic [7:0] E_STALL = 8'b0000_0000;
    localparam logic [7:0] E_LU    = 8'b0001_1110;
    localparam logic [7:0] E_BR    = 8'b1111_1110;
    localparam logic [7:0] E_INIT  = 8'b0010_1000;
    localparam logic [7:0] E_HALT  = 8'b0000_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;

    logic pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, memwb_we, hlt;
    logic pc_we_w, ifid_we_w, ifid_fl_w, idex_we_w, idex_fl_w, exmem_we_w, memwb_we_w, hlt_w;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [15:0] stall_cycles, flush_events, stall_cycles_w, flush_events_w;
`endif

    pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write_en(pc_we), .if_id_write_en(ifid_we), .if_id_flush(ifid_fl),
        .id_ex_write_en(idex_we), .id_ex_flush(idex_fl), .ex_mem_write_en(exmem_we),
        .mem_wb_write_en(memwb_we), .halted(hlt)
`ifdef HAZARD_PERF_COUNTERS_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(4), .CNT_W(16)) dut_wd (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write_en(pc_we_w), .if_id_write_en(ifid_we_w), .if_id_flush(ifid_fl_w),
        .id_ex_write_en(idex_we_w), .id_ex_flush(idex_fl_w), .ex_mem_write_en(exmem_we_w),
        .mem_wb_write_en(memwb_we_w), .halted(hlt_w)
`ifdef HAZARD_PERF_COUNTERS_EN
        , .stall_cycles(stall_cycles_w), .flush_events(flush_events_w)
`endif
    );

    logic [7:0] obs, obs_w;
    assign obs   = {pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, memwb_we, hlt};
    assign obs_w = {pc_we_w, ifid_we_w, ifid_fl_w, idex_we_w, idex_fl_w, exmem_we_w, memwb_we_w, hlt_w};

    typedef struct {
        logic [AW-1:0] rs1, rs2, rd;
        logic          u1, u2, mr, bt, req, rdy;
        logic [7:0]    exp;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic [AW-1:0] rs1, rs2, rd,
                                input logic u1, u2, mr, bt, req, rdy, input logic [7:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.u1 = u1; v.u2 = u2; v.mr = mr; v.bt = bt; v.req = req; v.rdy = rdy;
        v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; ex_rd = v.rd;
        id_uses_rs1 = v.u1; id_uses_rs2 = v.u2; ex_mem_read = v.mr;
        ex_branch_taken = v.bt; mem_req = v.req; mem_ready = v.rdy;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    initial begin
        vec_t idle_v, lu_v, wait_v;
        idle_v = mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN);
        lu_v   = mk(3'd3, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
        wait_v = mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL);

        vecs[0]  = idle_v;
        vecs[1]  = lu_v;
        vecs[2]  = idle_v;
        vecs[3]  = mk(3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN);
        vecs[4]  = mk(3'd1, 3'd5, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
        vecs[5]  = mk(3'd1, 3'd5, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN);
        vecs[6]  = mk(3'd3, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN);
        vecs[7]  = mk(3'd3, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_BR);
        vecs[8]  = mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_RUN);
        for (int i = 9; i < 14; i++) vecs[i] = wait_v;
        vecs[14] = mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_RUN);
        vecs[15] = idle_v;
        vecs[16] = mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_STALL);
        vecs[17] = vecs[16];
        vecs[18] = mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, E_BR);
        vecs[19] = mk(3'd3, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, E_STALL);
        vecs[20] = mk(3'd3, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, E_LU);
        vecs[21] = idle_v;
        vecs[22] = wait_v;
        vecs[23] = mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_STALL);
        vecs[24] = mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_RUN);

        drive(idle_v);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("reset_hold", {24'd0, obs}, {24'd0, E_INIT});
        @(negedge clk) rst = 1'b0;
        #1 check("init_cycle", {24'd0, obs}, {24'd0, E_INIT});

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1 check($sformatf("vec%0d", i), {24'd0, obs}, {24'd0, vecs[i].exp});
        end

        // Asynchronous reset while waiting on memory.
        @(negedge clk); drive(wait_v);
        #1 check("midwait_enter", {24'd0, obs}, {24'd0, E_STALL});
        @(negedge clk);
        #1 check("midwait_hold", {24'd0, obs}, {24'd0, E_STALL});
        #1 rst = 1'b1;
        #1 check("midwait_async_rst", {24'd0, obs}, {24'd0, E_INIT});
        @(negedge clk); rst = 1'b0; drive(idle_v);
        #1 check("midwait_init", {24'd0, obs}, {24'd0, E_INIT});
        @(negedge clk);
        #1 check("midwait_run", {24'd0, obs}, {24'd0, E_RUN});

        // Watchdog with MEM_TIMEOUT=4: entry cycle plus four wait cycles, then sticky halt.
        @(negedge clk); drive(wait_v);
        for (int k = 0; k < 8; k++) begin
            if (k == 6) mem_ready = 1'b1;
            #1;
            if (k < 5) check($sformatf("wd_wait%0d", k), {24'd0, obs_w}, {24'd0, E_STALL});
            else       check($sformatf("wd_halt%0d", k), {24'd0, obs_w}, {24'd0, E_HALT});
            if (k == 5) check("nowd_no_halt", {24'd0, obs}, {24'd0, E_STALL});
            @(negedge clk);
        end
        rst = 1'b1;
        #1 check("wd_rst_clear", {24'd0, obs_w}, {24'd0, E_INIT});
        @(negedge clk); rst = 1'b0; drive(idle_v);
        @(negedge clk);
        #1 check("wd_run_after_rst", {24'd0, obs_w}, {24'd0, E_RUN});

`ifdef HAZARD_PERF_COUNTERS_EN
        rst = 1'b1;
        #1 check("perf_rst", {16'd0, stall_cycles}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); drive(lu_v);
        @(negedge clk); drive(idle_v);
        @(negedge clk); drive(lu_v);
        @(negedge clk); drive(idle_v);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(wait_v);
        end
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); drive(idle_v);
        #1 check("perf_stall5", {16'd0, stall_cycles}, 32'd5);
        check("perf_flush0", {16'd0, flush_events}, 32'd0);
        @(negedge clk); ex_branch_taken = 1'b1;
        @(negedge clk); drive(idle_v);
        #1 check("perf_flush1", {16'd0, flush_events}, 32'd1);
        check("perf_stall_keep", {16'd0, stall_cycles}, 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
